// File: rtl/rs_single_error_corrector.sv
// rs_single_error_corrector: locates and fixes at most one RS(15,13) symbol error over GF(16)
// by stepping p = s1*alpha^j until it matches s2, then XORs q = s1*alpha^-j into symbol j.
module rs_single_error_corrector #(
    parameter int N            = 15,
    parameter int K            = 13,
    parameter int SYMBOL_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*SYMBOL_WIDTH-1:0]  in_codeword,
    input  logic [SYMBOL_WIDTH-1:0]    in_s1,
    input  logic [SYMBOL_WIDTH-1:0]    in_s2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N*SYMBOL_WIDTH-1:0]  out_codeword,
    output logic [K*SYMBOL_WIDTH-1:0]  out_msg,
    output logic [3:0]                 out_err_pos,
    output logic                       out_corrected,
    output logic                       out_uncorrectable
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
    state_t                      r_state;
    logic [N*SYMBOL_WIDTH-1:0]   r_cw;
    logic [3:0]                  r_s2, r_p, r_q, r_j, r_pos;
    logic                        r_valid, r_corr, r_unc;
    logic [3:0]                  w_p_next, w_q_next;
    logic [5:0]                  w_base;
    always_comb begin
        w_p_next = {r_p[2:0], 1'b0} ^ (r_p[3] ? 4'b0011 : 4'b0000);
        w_q_next = {1'b0, r_q[3:1]} ^ (r_q[0] ? 4'b1001 : 4'b0000);
        w_base   = {r_j, 2'b00};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cw    <= '0;
            r_s2    <= '0;
            r_p     <= '0;
            r_q     <= '0;
            r_j     <= '0;
            r_pos   <= '0;
            r_valid <= 1'b0;
            r_corr  <= 1'b0;
            r_unc   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_cw   <= in_codeword;
                    r_s2   <= in_s2;
                    r_p    <= in_s1;
                    r_q    <= in_s1;
                    r_j    <= '0;
                    r_pos  <= '0;
                    r_corr <= 1'b0;
                    r_unc  <= (in_s1 == '0) != (in_s2 == '0);
                    if (in_s1 == '0 || in_s2 == '0) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= SEARCH;
                    end
                end
                SEARCH: if (r_p == r_s2) begin
                    r_cw[w_base +: 4] <= r_cw[w_base +: 4] ^ r_q;
                    r_pos   <= r_j;
                    r_corr  <= 1'b1;
                    r_state <= DONE;
                    r_valid <= 1'b1;
                end else if (r_j == 4'd14) begin
                    // consistent syndromes always match before here
                    r_unc   <= 1'b1;
                    r_state <= DONE;
                    r_valid <= 1'b1;
                end else begin
                    r_j <= r_j + 4'd1;
                    r_p <= w_p_next;
                    r_q <= w_q_next;
                end
                DONE: if (out_ready) begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_corr  <= 1'b0;
                    r_unc   <= 1'b0;
                    r_pos   <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign in_ready          = (r_state == IDLE);
    assign out_valid         = r_valid;
    assign out_codeword      = r_cw;
    assign out_msg           = r_cw[N*SYMBOL_WIDTH-1:(N-K)*SYMBOL_WIDTH];
    assign out_err_pos       = r_pos;
    assign out_corrected     = r_corr;
    assign out_uncorrectable = r_unc;
endmodule

// File: tb/tb_rs_single_error_corrector.sv
// tb_rs_single_error_corrector: random and directed words checked against a log/antilog GF(16) model
module tb_rs_single_error_corrector;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [59:0] in_codeword = '0, out_codeword;
    logic [3:0]  in_s1 = '0, in_s2 = '0, out_err_pos;
    logic [51:0] out_msg;
    logic        out_corrected, out_uncorrectable;
    int          n_tests = 0, n_fail = 0;
    int          gexp[15];
    int          glog[16];

    rs_single_error_corrector dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_codeword(in_codeword), .in_s1(in_s1), .in_s2(in_s2),
        .out_valid(out_valid), .out_ready(out_ready), .out_codeword(out_codeword),
        .out_msg(out_msg), .out_err_pos(out_err_pos), .out_corrected(out_corrected),
        .out_uncorrectable(out_uncorrectable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        return (a == 0 || b == 0) ? 0 : gexp[(glog[a] + glog[b]) % 15];
    endfunction

    function automatic int gdiv(input int a, input int b);
        return (a == 0) ? 0 : gexp[(glog[a] - glog[b] + 15) % 15];
    endfunction

    task automatic run_word(input logic [59:0] cw, input int s1, input int s2, input int hold);
        logic [59:0] exp_cw = cw;
        int exp_lat = 1, exp_pos = 0, j, e, lat = 0;
        logic exp_corr = 0, exp_unc = 0;
        logic [68:0] snap;
        if (s1 != 0 && s2 != 0) begin
            // single error e at j: s1 = e*a^j, s2 = e*a^2j  =>  a^j = s2/s1, e = s1^2/s2
            j = (glog[s2] - glog[s1] + 15) % 15;
            e = gdiv(gmul(s1, s1), s2);
            exp_cw[j*4 +: 4] = exp_cw[j*4 +: 4] ^ 4'(e);
            exp_lat = 2 + j;
            exp_pos = j;
            exp_corr = 1;
        end else if (s1 != 0 || s2 != 0) begin
            exp_unc = 1;
        end
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1; in_codeword = cw; in_s1 = 4'(s1); in_s2 = 4'(s2);
        @(posedge clk);
        #1 in_valid = 0; in_codeword = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("in_ready_busy", 64'(in_ready), 64'd0);
        end while (!out_valid && lat < 40);
        check("latency", 64'(lat), 64'(exp_lat));
        check("codeword", 64'(out_codeword), 64'(exp_cw));
        check("msg", 64'(out_msg), 64'(exp_cw[59:8]));
        check("err_pos", 64'(out_err_pos), 64'(exp_pos));
        check("flags", 64'({out_corrected, out_uncorrectable}), 64'({exp_corr, exp_unc}));
        snap = {out_corrected, out_uncorrectable, out_err_pos, out_codeword};
        repeat (hold) @(negedge clk);
        if (hold > 0)
            check("stall_stable", 64'({out_valid, in_ready, snap[68:60], snap[59:0] ^ out_codeword}),
                  64'({1'b1, 1'b0, snap[68:60], 60'd0}));
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check("release", 64'({out_valid, in_ready, out_corrected, out_uncorrectable}), 64'(4'b0100));
    endtask

    initial begin
        logic [59:0] cw;
        int j, e, kind, x = 1, seen;
        for (int i = 0; i < 15; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x << 1;
            if (x & 16) x = x ^ 19;
        end
        glog[0] = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rst_state", 64'({in_ready, out_valid, out_corrected, out_uncorrectable, out_err_pos}),
              64'(8'b1000_0000));
        check("rst_cw", 64'(out_codeword), 64'd0);

        run_word(60'd0, 0, 0, 0);
        run_word(60'h1 << 12, 4'b1000, 4'b1100, 0);
        run_word(60'h4, 4'b0100, 4'b0100, 0);
        run_word(60'h1 << 56, 4'b1001, 4'b1101, 0);
        cw[31:0] = $urandom; cw[59:32] = 28'($urandom);
        run_word(cw, 4'b0001, 0, 0);
        run_word(cw, 0, 4'b0110, 10);

        // reset mid-search: word is dropped and the block recovers
        @(negedge clk);
        in_valid = 1; in_codeword = cw; in_s1 = 4'(gexp[10]); in_s2 = 4'(gexp[5]);
        @(posedge clk);
        #1 in_valid = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        check("rst_drop", 64'({seen[7:0], in_ready}), 64'({8'd0, 1'b1}));
        run_word(cw, gexp[3], gexp[6], 2);

        for (int t = 0; t < 40; t++) begin
            cw[31:0] = $urandom; cw[59:32] = 28'($urandom);
            kind = $urandom_range(0, 7);
            j = $urandom_range(0, 14);
            e = $urandom_range(1, 15);
            if (kind == 0) run_word(cw, 0, 0, $urandom_range(0, 3));
            else if (kind == 1) run_word(cw, 0, $urandom_range(1, 15), $urandom_range(0, 3));
            else run_word(cw, gmul(e, gexp[j]), gmul(e, gexp[(2 * j) % 15]), $urandom_range(0, 3));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rs_single_error_corrector.md
Name: rs_single_error_corrector

Overview:
- Sequential stage directly downstream of the RS(15,13) syndrome computer. It consumes the received codeword and the syndromes s1/s2, and locates at most one symbol error by stepping through positions 0..14.
- It XORs the error magnitude into the located symbol and emits the corrected codeword and the 13-symbol message over a valid/ready handshake.
- Field is GF(16), primitive polynomial x^4+x+1, alpha = 4'b0010.
- Syndrome convention: s1 = sum v_i*alpha^i and s2 = sum v_i*alpha^(2i), where symbol i occupies v[4i+3:4i].

Parameters:
- N, 15, codeword length in symbols (only default legal)
- K, 13, message length in symbols (only default legal)
- SYMBOL_WIDTH, 4, bits per symbol (GF(16) arithmetic hardwired; only default legal)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  codeword and syndromes valid
- in_ready  out  1  block can accept; high only in IDLE
- in_codeword  in  N*SYMBOL_WIDTH  received codeword, symbol i at [4i+3:4i]
- in_s1  in  SYMBOL_WIDTH  syndrome 1
- in_s2  in  SYMBOL_WIDTH  syndrome 2
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts
- out_codeword  out  N*SYMBOL_WIDTH  corrected codeword (unchanged if uncorrectable)
- out_msg  out  K*SYMBOL_WIDTH  out_codeword[N*4-1:(N-K)*4] (systematic message symbols 2..14)
- out_err_pos  out  4  located error index j; 0 when no correction made
- out_corrected  out  1  one symbol was corrected
- out_uncorrectable  out  1  error pattern detected but not correctable

Behaviour:
- Reset: state=IDLE; out_valid=0, out_codeword=0, out_err_pos=0, out_corrected=0, out_uncorrectable=0, counter j=0. in_ready=1 the cycle after reset deasserts.
- Reset mid-operation: any in-flight word is discarded. No output is produced for it.
- IDLE: in_ready=1. On in_valid&&in_ready, latch the codeword, s1, s2; initialise p=s1, q=s1, j=0. Next state depends on the syndromes:
  - s1==0 && s2==0 -> DONE with flags clear (no error).
  - exactly one of s1/s2 zero -> DONE, out_uncorrectable=1.
  - otherwise -> SEARCH.
- SEARCH: one position per cycle. If p==s2:
  - symbol j ^= q; out_err_pos=j; out_corrected=1; go to DONE.
  - Else if j==14: out_uncorrectable=1, go to DONE. This branch is defensive and unreachable for consistent syndromes.
  - Else: j=j+1; p=p*alpha; q=q*alpha^14 (i.e. alpha^-1). Both are constant GF multiplies; no general multiplier is needed.
- DONE: out_valid=1. Outputs are stable while out_valid && !out_ready. On out_ready, go to IDLE; flags and out_valid clear that edge.
- Latency, counted from the accept edge at cycle T:
  - no-error or uncorrectable-by-syndrome: out_valid at T+1.
  - error at j: out_valid at T+2+j (max T+16).
  - defensive exhaust: T+16.
- No overlap: in_ready=0 in SEARCH and DONE. in_valid is ignored there and the upstream must hold its data.
- Uncorrectable: out_codeword equals the received codeword bit-exact, and out_err_pos=0.
- Arithmetic is mod x^4+x+1:
  - x*alpha = {x[2:0],0} ^ (x[3] ? 4'b0011 : 0)
  - x*alpha^-1 = {0,x[3:1]} ^ (x[0] ? 4'b1001 : 0)

Test Plan:
- All-zero codeword, s1=0, s2=0 -> out_valid at T+1; codeword all zero; corrected=0, uncorrectable=0, err_pos=0.
- Zero codeword with symbol 3=4'b0001, s1=4'b1000, s2=4'b1100 -> out_valid at T+5; out symbol 3=0; err_pos=3; corrected=1.
- Zero codeword with symbol 0=4'b0100, s1=4'b0100, s2=4'b0100 -> out_valid at T+2; codeword zero; err_pos=0; corrected=1.
- Zero codeword with symbol 14=4'b0001, s1=4'b1001, s2=4'b1101 -> out_valid at T+16; out_msg zero; err_pos=14; corrected=1.
- s1=4'b0001, s2=0, arbitrary codeword -> out_valid at T+1; uncorrectable=1; codeword passed unchanged.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Then release -> in_ready=1 next cycle.
  - Assert rst during SEARCH -> no out_valid; block returns to IDLE and accepts a new word cleanly.
